// File: rtl/w_pattern_pkg.sv
// Shared state codes and widths for the w_pattern_ctrl run detector.
// Imported by the controller top and its hold timer.
package w_pattern_pkg;

    localparam int STATE_W = 3;
    localparam int HOLD_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'b000,
        S_RUN0 = 3'b001,
        S_RUN1 = 3'b010,
        S_HIT  = 3'b011,
        S_HOLD = 3'b100
    } state_e;

endpackage

// File: rtl/w_pattern_timer.sv
// 8-bit loadable down-counter backing the HOLD window of w_pattern_ctrl.
// Load wins over decrement; decrement stops at zero instead of wrapping.
module w_pattern_timer
    import w_pattern_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [HOLD_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_o
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/w_pattern_ctrl.sv
// Moore run detector: RUN_LEN equal qualified w samples -> HIT, then HOLD for HOLD_CYCLES.
// Optional saturating hit counter on match_count_o when W_PATTERN_MATCH_CNT_EN is defined.
module w_pattern_ctrl
    import w_pattern_pkg::*;
#(
    parameter int RUN_LEN     = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               w_i,
    output logic               led_out_o,
    output logic               counter_rst_o,
`ifdef W_PATTERN_MATCH_CNT_EN
    output logic [7:0]         match_count_o,
`endif
    output logic [STATE_W-1:0] state_o
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] run_cnt_q;
    logic [CNT_W-1:0] run_cnt_d;
    logic             hold_load;
    logic             hold_dec;
    logic             hold_zero;
    logic             same_level;

    // In RUN1 a 1 continues the run, in RUN0 a 0 does.
    assign same_level = ((state_q == S_RUN1) == w_i);

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d   = w_i ? S_RUN1 : S_RUN0;
                    run_cnt_d = CNT_W'(1);
                end
            end
            S_RUN0, S_RUN1: begin
                if (!enable_i) begin
                    state_d   = S_IDLE;
                    run_cnt_d = '0;
                end else if (same_level) begin
                    if (run_cnt_q == CNT_W'(RUN_LEN - 1)) begin
                        state_d   = S_HIT;
                        run_cnt_d = '0;
                    end else begin
                        run_cnt_d = run_cnt_q + CNT_W'(1);
                    end
                end else begin
                    // The opposite value is the first sample of a fresh run.
                    state_d   = w_i ? S_RUN1 : S_RUN0;
                    run_cnt_d = CNT_W'(1);
                end
            end
            S_HIT: begin
                hold_load = 1'b1;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (hold_zero) begin
                    state_d = S_IDLE;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                run_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    w_pattern_timer u_hold_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (hold_load),
        .load_val_i (HOLD_W'(HOLD_CYCLES - 1)),
        .dec_i      (hold_dec),
        .zero_o     (hold_zero)
    );

`ifdef W_PATTERN_MATCH_CNT_EN
    logic [7:0] match_cnt_q;
    logic [7:0] match_cnt_d;

    always_comb begin
        match_cnt_d = match_cnt_q;
        if ((state_d == S_HIT) && (state_q != S_HIT) && (match_cnt_q != 8'hFF)) begin
            match_cnt_d = match_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            match_cnt_q <= '0;
        end else begin
            match_cnt_q <= match_cnt_d;
        end
    end

    assign match_count_o = match_cnt_q;
`endif

    assign led_out_o     = (state_q == S_HIT) || (state_q == S_HOLD);
    assign counter_rst_o = (state_q == S_IDLE) || (state_q == S_HIT);
    assign state_o       = state_q;

endmodule

// File: tb/tb_w_pattern_ctrl.sv
// Bench for w_pattern_ctrl: directed scenarios plus random stimulus against a sample-history model.
// Define W_PATTERN_MATCH_CNT_EN to also exercise match_count_o.
module tb_w_pattern_ctrl;

  localparam int RUN_LEN     = 4;
  localparam int HOLD_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       w = 1'b0;
  logic       led_out;
  logic       counter_rst;
  logic [2:0] state;
`ifdef W_PATTERN_MATCH_CNT_EN
  logic [7:0] match_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: qualified samples since detection restarted, and cycles of led left.
  logic m_samples[$];
  int   m_busy_left = 0;
  int   m_hits = 0;

  always #5 clk = ~clk;

  w_pattern_ctrl #(
    .RUN_LEN     (RUN_LEN),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .w_i           (w),
    .led_out_o     (led_out),
    .counter_rst_o (counter_rst),
`ifdef W_PATTERN_MATCH_CNT_EN
    .match_count_o (match_count),
`endif
    .state_o       (state)
  );

  task automatic model_reset();
    m_samples.delete();
    m_busy_left = 0;
    m_hits = 0;
  endtask

  task automatic model_edge(input logic en, input logic wv);
    int run;
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (!en) begin
      m_samples.delete();
    end else begin
      m_samples.push_back(wv);
      run = 0;
      for (int i = m_samples.size() - 1; i >= 0; i--) begin
        if (m_samples[i] != wv) break;
        run++;
      end
      if (run >= RUN_LEN) begin
        m_busy_left = 1 + HOLD_CYCLES;
        m_samples.delete();
        if (m_hits < 255) m_hits++;
      end
    end
  endtask

  function automatic logic [2:0] exp_state();
    if (m_busy_left == 1 + HOLD_CYCLES) return 3'b011;
    if (m_busy_left > 0) return 3'b100;
    if (m_samples.size() == 0) return 3'b000;
    return m_samples[m_samples.size() - 1] ? 3'b010 : 3'b001;
  endfunction

  function automatic logic exp_led();
    return m_busy_left > 0;
  endfunction

  function automatic logic exp_crst();
    return (exp_state() == 3'b000) || (exp_state() == 3'b011);
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic en, input logic wv);
    enable = en;
    w = wv;
    @(posedge clk);
    model_edge(en, wv);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_vec++;
    if (state !== 3'b000 || led_out !== 1'b0 || counter_rst !== 1'b1) begin
      n_err++;
      $display("FAIL reset_init: state=%b led=%b crst=%b required 000 0 1", state, led_out, counter_rst);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < RUN_LEN; i++) step(1'b1, 1'b1);
    n_vec++;
    if (state !== 3'b011 || led_out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_prehit: state=%b led=%b required 011 1", state, led_out);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (state !== 3'b000 || led_out !== 1'b0 || counter_rst !== 1'b1) begin
      n_err++;
      $display("FAIL reset_async: state=%b led=%b crst=%b required 000 0 1", state, led_out, counter_rst);
    end
`ifdef W_PATTERN_MATCH_CNT_EN
    n_vec++;
    if (match_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_match_count: got %0d required 0", match_count);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_all_ones();
    int leds;
    int crsts;
    logic done;
    for (int i = 1; i <= RUN_LEN; i++) begin
      step(1'b1, 1'b1);
      n_vec++;
      if (state !== ((i < RUN_LEN) ? 3'b010 : 3'b011)) begin
        n_err++;
        $display("FAIL ones_state edge%0d: got %b required %b", i, state, (i < RUN_LEN) ? 3'b010 : 3'b011);
      end
    end
    leds = led_out ? 1 : 0;
    crsts = (led_out && counter_rst) ? 1 : 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (!led_out) done = 1'b1;
      else begin
        leds++;
        if (counter_rst) crsts++;
      end
    end
    n_vec++;
    if (leds != 1 + HOLD_CYCLES || crsts != 1 || state !== 3'b000) begin
      n_err++;
      $display("FAIL ones_hold: led_cycles=%0d crst_cycles=%0d state=%b required %0d 1 000",
               leds, crsts, state, 1 + HOLD_CYCLES);
    end
  endtask

  task automatic test_switch_run();
    logic       seq[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] req;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, seq[i]);
      req = (i < 3) ? 3'b001 : (i < 6) ? 3'b010 : 3'b011;
      n_vec++;
      if (state !== req || led_out !== (i == 6)) begin
        n_err++;
        $display("FAIL switch_run sample%0d: state=%b led=%b required %b %b", i + 1, state, led_out, req, (i == 6));
      end
    end
    for (int i = 0; i < 1 + HOLD_CYCLES; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_enable_drop();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_vec++;
    if (state !== 3'b000) begin
      n_err++;
      $display("FAIL enable_drop_idle: got %b required 000", state);
    end
    for (int i = 0; i < RUN_LEN - 1; i++) begin
      step(1'b1, 1'b0);
      n_vec++;
      if (state !== 3'b001 || led_out !== 1'b0) begin
        n_err++;
        $display("FAIL enable_drop_nohit sample%0d: state=%b led=%b required 001 0", i + 1, state, led_out);
      end
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_hold_toggle();
    for (int i = 0; i < RUN_LEN; i++) step(1'b1, 1'b1);
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      step(1'b1, 1'(i));
      n_vec++;
      if (state !== 3'b100 || led_out !== 1'b1) begin
        n_err++;
        $display("FAIL hold_toggle cycle%0d: state=%b led=%b required 100 1", i, state, led_out);
      end
    end
    step(1'b1, 1'b1);
    n_vec++;
    if (state !== 3'b000 || led_out !== 1'b0) begin
      n_err++;
      $display("FAIL hold_toggle_exit: state=%b led=%b required 000 0", state, led_out);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic en;
    logic wv = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) wv = ~wv;
      step(en, wv);
      n_vec++;
      if (state !== exp_state() || led_out !== exp_led() || counter_rst !== exp_crst()) begin
        n_err++;
        $display("FAIL random cycle%0d: state=%b led=%b crst=%b required %b %b %b",
                 i, state, led_out, counter_rst, exp_state(), exp_led(), exp_crst());
      end
`ifdef W_PATTERN_MATCH_CNT_EN
      n_vec++;
      if (match_count !== 8'(m_hits)) begin
        n_err++;
        $display("FAIL random_match_count cycle%0d: got %0d required %0d", i, match_count, m_hits);
      end
`endif
    end
  endtask

`ifdef W_PATTERN_MATCH_CNT_EN
  task automatic test_saturate();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 257; k++) begin
      for (int i = 0; i < RUN_LEN; i++) step(1'b1, 1'b1);
      n_vec++;
      if (match_count !== 8'((k < 255) ? k : 255) || state !== 3'b011) begin
        n_err++;
        $display("FAIL saturate hit%0d: count=%0d state=%b required %0d 011", k, match_count, state,
                 (k < 255) ? k : 255);
      end
      for (int i = 0; i < 1 + HOLD_CYCLES; i++) step(1'b0, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ones();
    test_switch_run();
    test_enable_drop();
    test_hold_toggle();
    test_random();
`ifdef W_PATTERN_MATCH_CNT_EN
    test_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
